muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative unsigned multiply/divide engine that owns the HI and LO special-purpose registers. The ALU issues MULT and DIV to it, and MFHI and MFLO read its results. It replaces the single-cycle combinational product and quotient with a WIDTH-cycle shift-add and restoring-divide datapath. A busy/done handshake lets the control unit stall dependent MFHI/MFLO instructions.

## Interface
- WIDTH, 32, operand and result width; HI and LO are each WIDTH bits.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled on each rising edge.
- op  input  1  operation select: 0 = MULT, 1 = DIV.
- a  input  WIDTH  multiplicand or dividend; unsigned.
- b  input  WIDTH  multiplier or divisor; unsigned.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse; HI and LO hold the new result in this cycle.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.
- div_by_zero  output  1  set when the last completed op was DIV with b == 0.

## Operation
- States:
  - IDLE: reset state.
  - MUL and DIV: iterating; busy=1.
  - DONE: done=1, busy=0.
- Acceptance: start=1 in IDLE or DONE is accepted at that edge.
  - a, b and op are latched into internal operand registers.
  - An iteration counter is loaded with WIDTH-1.
  - div_by_zero clears.
  - Next state is MUL (op=0) or DIV (op=1).
- start while busy=1 is ignored: no queuing, no effect on the op in flight.
- DIV with b == 0 is detected at acceptance:
  - No iteration runs; next state is DONE.
  - hi=0, lo=0 and div_by_zero=1 are written at that same edge.
- MUL uses shift-add with a 2*WIDTH accumulator {acc_hi, acc_lo}. acc_lo is initialised to a, acc_hi to 0. Each cycle:
  - if acc_lo[0]=1, add b to acc_hi, keeping the carry out;
  - shift the whole accumulator, including that carry, right by one.
- DIV uses restoring division with a WIDTH+1 bit partial remainder r (initially 0) and a shift register q (initially a). Each cycle:
  - shift {r, q} left by one;
  - if r >= b, set r = r - b and q[0] = 1.
- Completion: on the edge where the counter is 0, the state moves to DONE and the results are written:
  - MUL: hi = acc_hi, lo = acc_lo.
  - DIV: lo = quotient q, hi = remainder r[WIDTH-1:0].
- Result mapping follows MIPS: LO = quotient, HI = remainder.
- hi and lo change only on a completion edge. Intermediate values never appear on the outputs, so MFHI/MFLO during busy reads the previous result.
- DONE lasts one cycle. The next state is IDLE, or MUL/DIV if start is accepted in DONE.
- div_by_zero holds until the next accepted start.
- Arithmetic is unsigned and modulo nothing: the full 2*WIDTH product is retained. Remainder is always < b.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Counter and operand registers are cleared.
- Reset mid-operation aborts the op; no partial result is written.
- Normal latency:
  - start is sampled high in cycle 0.
  - busy=1 in cycles 1..WIDTH.
  - done=1 and new hi/lo in cycle WIDTH+1, which is cycle 33 for WIDTH=32.
- Divide-by-zero latency: start in cycle 0; done=1 with hi=lo=0 and div_by_zero=1 in cycle 1.
- busy and done are never high together.
- Back-to-back: start in the DONE cycle gives busy=1 in the next cycle, with no IDLE bubble.
- Throughput: one op per WIDTH+1 cycles.
- Outputs are registered; there is no combinational path from start, a or b to any output.

## Test plan
- MULT a=7, b=6, start in cycle 0 -> busy in cycles 1-32; done in cycle 33 with hi=0x00000000, lo=0x0000002A.
- MULT a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV 100/7 -> lo=14, hi=2.
- DIV 5/9 -> lo=0, hi=5.
- DIV 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- DIV a=123, b=0 -> done in cycle 1 with hi=0, lo=0, div_by_zero=1. A following MULT 3*4 clears the flag at acceptance, then gives lo=12.
- MULT 7*6 started, then start=1 with DIV 9/3 in cycle 5 -> ignored; result is lo=42. DIV 9/3 issued in the DONE cycle is accepted -> 33 cycles later lo=3, hi=0.
- Reset pulsed in cycle 10 of DIV 100/7 (prior hi/lo=42) -> same cycle hi=lo=0, busy=0, done=0. A new MULT 2*3 after reset gives lo=6 at the expected latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide engine owning HI/LO.
// MULT uses shift-add, DIV uses restoring division; each takes WIDTH cycles plus a one-cycle DONE.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] b_reg;
    // acc_hi is the product upper half in MUL and the partial remainder in DIV;
    // the remainder is always < b, so the extra bit exists only in div_shift.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;
    logic             accept;

    always_comb begin
        addend    = acc_lo[0] ? b_reg : '0;
        mul_sum   = {1'b0, acc_hi} + {1'b0, addend};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        if (state == S_DIV) begin
            next_hi = div_ge ? (div_shift[WIDTH-1:0] - b_reg) : div_shift[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        busy   = (state == S_MUL) || (state == S_DIV);
        done   = (state == S_DONE);
        accept = start && ((state == S_IDLE) || (state == S_DONE));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            b_reg       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            b_reg  <= b;
            acc_hi <= '0;
            acc_lo <= a;
            count  <= CW'(WIDTH - 1);
            if (op && (b == '0)) begin
                state       <= S_DONE;
                hi          <= '0;
                lo          <= '0;
                div_by_zero <= 1'b1;
            end else begin
                state       <= op ? S_DIV : S_MUL;
                div_by_zero <= 1'b0;
            end
        end else begin
            case (state)
                S_MUL, S_DIV: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    count  <= count - CW'(1);
                    if (count == '0) begin
                        hi    <= next_hi;
                        lo    <= next_lo;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic d);
        logic [63:0] p;
        if (!o) begin
            p = 64'(x) * 64'(y);
            h = p[63:32];
            l = p[31:0];
            d = 1'b0;
        end else if (y == 0) begin
            h = '0;
            l = '0;
            d = 1'b1;
        end else begin
            l = x / y;
            h = x % y;
            d = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge (cycle 1).
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        model(o, x, y, exp_hi, exp_lo, exp_dbz);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        cyc   = 1;
    endtask

    task automatic wait_done(input string tag, input int lat);
        while (done !== 1'b1 && cyc < 60) begin
            chk({tag, ".busy"}, 64'(busy), 64'(1'b1));
            chk({tag, ".hold_hi"}, 64'(hi), 64'(prev_hi));
            chk({tag, ".hold_lo"}, 64'(lo), 64'(prev_lo));
            chk({tag, ".dbz_clr"}, 64'(div_by_zero), 64'(1'b0));
            step();
        end
        chk({tag, ".done"}, 64'(done), 64'(1'b1));
        chk({tag, ".latency"}, 64'(cyc), 64'(lat));
        chk({tag, ".busy_in_done"}, 64'(busy), 64'(1'b0));
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    task automatic run(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(o, x, y);
        wait_done(tag, (o && y == 0) ? 1 : W + 1);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        prev_hi = '0;
        prev_lo = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.busy", 64'(busy), 64'(1'b0));
        chk("rst.done", 64'(done), 64'(1'b0));
        chk("rst.hi", 64'(hi), 64'(0));
        chk("rst.lo", 64'(lo), 64'(0));
        chk("rst.dbz", 64'(div_by_zero), 64'(1'b0));
        @(negedge clock);
        reset = 1'b0;
        step();
        chk("idle.busy", 64'(busy), 64'(1'b0));

        run("mul_7x6", 1'b0, 32'd7, 32'd6);
        run("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("div_100_7", 1'b1, 32'd100, 32'd7);
        run("div_5_9", 1'b1, 32'd5, 32'd9);
        run("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1);
        run("div_by_0", 1'b1, 32'd123, 32'd0);
        run("mul_3x4", 1'b0, 32'd3, 32'd4);

        // start while busy must be ignored
        issue(1'b0, 32'd7, 32'd6);
        repeat (3) begin
            chk("ign.busy", 64'(busy), 64'(1'b1));
            step();
        end
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        step();
        start = 1'b0;
        wait_done("ign_mul", W + 1);
        run("b2b_div_9_3", 1'b1, 32'd9, 32'd3);

        // asynchronous reset mid-division
        run("pre_rst_mul", 1'b0, 32'd7, 32'd6);
        issue(1'b1, 32'd100, 32'd7);
        repeat (8) step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst.hi", 64'(hi), 64'(0));
        chk("arst.lo", 64'(lo), 64'(0));
        chk("arst.busy", 64'(busy), 64'(1'b0));
        chk("arst.done", 64'(done), 64'(1'b0));
        @(negedge clock);
        reset = 1'b0;
        step();
        prev_hi = '0;
        prev_lo = '0;
        run("post_rst_mul", 1'b0, 32'd2, 32'd3);

        for (int i = 0; i < 24; i++) begin
            logic         ro;
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            int           sel;
            ro  = 1'($urandom);
            rx  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 15));
                2:       ry = rx;
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                step();
                chk("rand.idle_done", 64'(done), 64'(1'b0));
            end
            run("rand", ro, rx, ry);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
